// File: rtl/cl2_trap_ctrl.sv
// ============================================================================
// Module   : cl2_trap_ctrl
// Brief    : M-mode trap CSRs plus the exception/interrupt/MRET sequencer
//            (IDLE -> DRAIN -> COMMIT -> REDIRECT). Optional macro
//            CL2_TRAP_VECTORED_EN enables mtvec vectored mode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cl2_trap_ctrl #(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
    parameter logic [31:0] MISA_VAL  = 32'h4000_1104
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        exc_valid_i,
    input  logic [4:0]  exc_cause_i,
    input  logic [31:0] exc_pc_i,
    input  logic [31:0] exc_tval_i,
    input  logic        mret_i,
    input  logic [31:0] next_pc_i,
    input  logic        irq_ext_i,
    input  logic        irq_sw_i,
    input  logic        irq_timer_i,
    output logic        evt_ready_o,
    output logic        flush_req_o,
    input  logic        flush_ack_i,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    input  logic        redirect_ready_i,
    input  logic        csr_we_i,
    input  logic [11:0] csr_addr_i,
    input  logic [31:0] csr_wdata_i,
    output logic [31:0] csr_rdata_o,
    output logic        csr_illegal_o,
    output logic        irq_pending_o
);

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_COMMIT, S_REDIRECT} state_e;

`ifdef CL2_TRAP_VECTORED_EN
    localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFC;
`endif

    state_e      state_q, state_d;
    logic        mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
    logic [2:0]  mie_q, mie_d;      // {MEIE, MTIE, MSIE}
    logic [2:0]  mip_q;             // {MEIP, MTIP, MSIP}
    logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
    logic        ev_mret_q, ev_mret_d, ev_irq_q, ev_irq_d;
    logic [4:0]  ev_cause_q, ev_cause_d;
    logic [31:0] ev_epc_q, ev_epc_d, ev_tval_q, ev_tval_d;
    logic [31:0] rpc_q, rpc_d;

    logic [2:0]  w_pend;
    logic [4:0]  w_irq_code;
    logic [31:0] w_base, w_vec;

    assign w_pend        = mip_q & mie_q & {3{mst_mie_q}};
    assign irq_pending_o = |w_pend;
    // Interrupt priority: external, then software, then timer.
    assign w_irq_code    = w_pend[2] ? 5'd11 : (w_pend[0] ? 5'd3 : 5'd7);

    assign w_base = {mtvec_q[31:2], 2'b00};
`ifdef CL2_TRAP_VECTORED_EN
    assign w_vec  = (ev_irq_q && (mtvec_q[1:0] == 2'b01))
                  ? w_base + {25'd0, ev_cause_q, 2'b00} : w_base;
`else
    assign w_vec  = w_base;
`endif

    assign evt_ready_o      = (state_q == S_IDLE);
    assign flush_req_o      = (state_q == S_DRAIN);
    assign redirect_valid_o = (state_q == S_REDIRECT);
    assign redirect_pc_o    = rpc_q;

    always_comb begin
        csr_rdata_o   = 32'd0;
        csr_illegal_o = 1'b0;
        case (csr_addr_i)
            12'h300: csr_rdata_o = {19'd0, 2'b11, 3'd0, mst_mpie_q, 3'd0, mst_mie_q, 3'd0};
            12'h301: csr_rdata_o = MISA_VAL;
            12'h304: csr_rdata_o = {20'd0, mie_q[2], 3'd0, mie_q[1], 3'd0, mie_q[0], 3'd0};
            12'h305: csr_rdata_o = mtvec_q;
            12'h340: csr_rdata_o = mscratch_q;
            12'h341: csr_rdata_o = mepc_q;
            12'h342: csr_rdata_o = mcause_q;
            12'h343: csr_rdata_o = mtval_q;
            12'h344: csr_rdata_o = {20'd0, mip_q[2], 3'd0, mip_q[1], 3'd0, mip_q[0], 3'd0};
            default: csr_illegal_o = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        mst_mie_d  = mst_mie_q;
        mst_mpie_d = mst_mpie_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        ev_mret_d  = ev_mret_q;
        ev_irq_d   = ev_irq_q;
        ev_cause_d = ev_cause_q;
        ev_epc_d   = ev_epc_q;
        ev_tval_d  = ev_tval_q;
        rpc_d      = rpc_q;
        case (state_q)
            S_IDLE: begin
                if (csr_we_i) begin
                    case (csr_addr_i)
                        12'h300: begin
                            mst_mie_d  = csr_wdata_i[3];
                            mst_mpie_d = csr_wdata_i[7];
                        end
                        12'h304: mie_d      = {csr_wdata_i[11], csr_wdata_i[7], csr_wdata_i[3]};
                        12'h305: mtvec_d    = csr_wdata_i & MTVEC_MASK;
                        12'h340: mscratch_d = csr_wdata_i;
                        12'h341: mepc_d     = {csr_wdata_i[31:1], 1'b0};
                        12'h342: mcause_d   = csr_wdata_i;
                        12'h343: mtval_d    = csr_wdata_i;
                        default: ;
                    endcase
                end
                if (mret_i) begin
                    ev_mret_d = 1'b1;
                    ev_irq_d  = 1'b0;
                    state_d   = S_DRAIN;
                end else if (exc_valid_i) begin
                    ev_mret_d  = 1'b0;
                    ev_irq_d   = 1'b0;
                    ev_cause_d = exc_cause_i;
                    ev_epc_d   = exc_pc_i;
                    ev_tval_d  = exc_tval_i;
                    state_d    = S_DRAIN;
                end else if (|w_pend) begin
                    ev_mret_d  = 1'b0;
                    ev_irq_d   = 1'b1;
                    ev_cause_d = w_irq_code;
                    ev_epc_d   = next_pc_i;
                    ev_tval_d  = 32'd0;
                    state_d    = S_DRAIN;
                end
            end
            S_DRAIN: if (flush_ack_i) state_d = S_COMMIT;
            S_COMMIT: begin
                if (ev_mret_q) begin
                    mst_mie_d  = mst_mpie_q;
                    mst_mpie_d = 1'b1;
                    rpc_d      = mepc_q;
                end else begin
                    mepc_d     = {ev_epc_q[31:1], 1'b0};
                    mcause_d   = {ev_irq_q, 26'd0, ev_cause_q};
                    mtval_d    = ev_tval_q;
                    mst_mpie_d = mst_mie_q;
                    mst_mie_d  = 1'b0;
                    rpc_d      = w_vec;
                end
                state_d = S_REDIRECT;
            end
            S_REDIRECT: if (redirect_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            mst_mie_q  <= 1'b0;
            mst_mpie_q <= 1'b0;
            mie_q      <= 3'd0;
            mip_q      <= 3'd0;
            mtvec_q    <= MTVEC_RST & MTVEC_MASK;
            mscratch_q <= 32'd0;
            mepc_q     <= 32'd0;
            mcause_q   <= 32'd0;
            mtval_q    <= 32'd0;
            ev_mret_q  <= 1'b0;
            ev_irq_q   <= 1'b0;
            ev_cause_q <= 5'd0;
            ev_epc_q   <= 32'd0;
            ev_tval_q  <= 32'd0;
            rpc_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            mst_mie_q  <= mst_mie_d;
            mst_mpie_q <= mst_mpie_d;
            mie_q      <= mie_d;
            mip_q      <= {irq_ext_i, irq_timer_i, irq_sw_i};
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            ev_mret_q  <= ev_mret_d;
            ev_irq_q   <= ev_irq_d;
            ev_cause_q <= ev_cause_d;
            ev_epc_q   <= ev_epc_d;
            ev_tval_q  <= ev_tval_d;
            rpc_q      <= rpc_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cl2_trap_ctrl.sv
// ============================================================================
// Module   : tb_cl2_trap_ctrl
// Brief    : Scoreboard bench for cl2_trap_ctrl; expected redirects are queued
//            by the stimulus thread and consumed by a redirect monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cl2_trap_ctrl;

    localparam logic [31:0] MISA_VAL = 32'h4000_1104;
`ifdef CL2_TRAP_VECTORED_EN
    localparam bit VEC = 1'b1;
`else
    localparam bit VEC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        exc_valid_i = 1'b0, mret_i = 1'b0;
    logic [4:0]  exc_cause_i = '0;
    logic [31:0] exc_pc_i = '0, exc_tval_i = '0, next_pc_i = '0;
    logic        irq_ext_i = 1'b0, irq_sw_i = 1'b0, irq_timer_i = 1'b0;
    logic        evt_ready_o, flush_req_o, flush_ack_i = 1'b0;
    logic        redirect_valid_o, redirect_ready_i = 1'b0;
    logic [31:0] redirect_pc_o;
    logic        csr_we_i = 1'b0;
    logic [11:0] csr_addr_i = '0;
    logic [31:0] csr_wdata_i = '0, csr_rdata_o;
    logic        csr_illegal_o, irq_pending_o;

    always #5 clk = ~clk;

    cl2_trap_ctrl dut (
        .clk_i(clk), .rst_i(rst_i),
        .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i),
        .exc_pc_i(exc_pc_i), .exc_tval_i(exc_tval_i),
        .mret_i(mret_i), .next_pc_i(next_pc_i),
        .irq_ext_i(irq_ext_i), .irq_sw_i(irq_sw_i), .irq_timer_i(irq_timer_i),
        .evt_ready_o(evt_ready_o), .flush_req_o(flush_req_o), .flush_ack_i(flush_ack_i),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
        .redirect_ready_i(redirect_ready_i),
        .csr_we_i(csr_we_i), .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i),
        .csr_rdata_o(csr_rdata_o), .csr_illegal_o(csr_illegal_o),
        .irq_pending_o(irq_pending_o)
    );

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Architectural model of the trap CSRs
    bit          m_mie, m_mpie;
    logic [31:0] m_mie_reg, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;

    function automatic void m_reset();
        m_mie = 0; m_mpie = 0; m_mie_reg = 0; m_mtvec = 0;
        m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return 32'h1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7);
            12'h301: return MISA_VAL;
            12'h304: return m_mie_reg;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            default: return 32'h0;
        endcase
    endfunction

    function automatic void m_write(input logic [11:0] a, input logic [31:0] d);
        case (a)
            12'h300: begin m_mie = d[3]; m_mpie = d[7]; end
            12'h304: m_mie_reg = d & 32'h888;
            12'h305: m_mtvec = VEC ? d : (d & ~32'h3);
            12'h340: m_mscratch = d;
            12'h341: m_mepc = d & ~32'h1;
            12'h342: m_mcause = d;
            12'h343: m_mtval = d;
            default: ;
        endcase
    endfunction

    function automatic void m_trap(input bit irq, input int code, input logic [31:0] epc,
                                   input logic [31:0] tval);
        logic [31:0] base = m_mtvec & ~32'h3;
        if (VEC && irq && m_mtvec[1:0] == 2'b01) exp_q.push_back(base + 32'(4 * code));
        else exp_q.push_back(base);
        m_mepc   = epc & ~32'h1;
        m_mcause = (irq ? 32'h8000_0000 : 32'h0) | 32'(code);
        m_mtval  = tval;
        m_mpie   = m_mie;
        m_mie    = 0;
    endfunction

    function automatic void m_mret();
        exp_q.push_back(m_mepc);
        m_mie  = m_mpie;
        m_mpie = 1;
    endfunction

    // Redirect monitor: every cycle the redirect is offered it must match the head
    always @(negedge clk) begin
        if (!rst_i && redirect_valid_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL redirect_unexpected actual=%h required=none", redirect_pc_o);
            end else begin
                chk("redirect_pc", redirect_pc_o, exp_q[0]);
                if (redirect_ready_i) void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        exp_q.delete();
        m_reset();
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        csr_we_i = 1'b1; csr_addr_i = a; csr_wdata_i = d;
        tick();
        csr_we_i = 1'b0;
        m_write(a, d);
    endtask

    task automatic csr_read(input logic [11:0] a);
        csr_addr_i = a;
        #1;
        chk($sformatf("csr_%h", a), csr_rdata_o, m_read(a));
        chk("csr_illegal_mapped", 32'(csr_illegal_o), 32'd0);
    endtask

    task automatic issue_exc(input logic [4:0] c, input logic [31:0] pc, input logic [31:0] tv);
        chk("evt_ready_idle", 32'(evt_ready_o), 32'd1);
        exc_valid_i = 1'b1; exc_cause_i = c; exc_pc_i = pc; exc_tval_i = tv;
        m_trap(0, int'(c), pc, tv);
        tick();
        exc_valid_i = 1'b0;
    endtask

    task automatic issue_mret(input bit with_exc);
        chk("evt_ready_idle", 32'(evt_ready_o), 32'd1);
        mret_i = 1'b1;
        exc_valid_i = with_exc; exc_cause_i = 5'd4; exc_pc_i = 32'h9990;
        m_mret();
        tick();
        mret_i = 1'b0; exc_valid_i = 1'b0;
    endtask

    task automatic drain(input int ack_dly, input bit wr_scratch);
        for (int i = 0; i < ack_dly; i++) begin
            chk("flush_req_drain", 32'(flush_req_o), 32'd1);
            if (wr_scratch && i == 0) begin
                csr_we_i = 1'b1; csr_addr_i = 12'h340; csr_wdata_i = 32'hBAD0_BAD0;
            end
            tick();
            csr_we_i = 1'b0;
        end
        chk("flush_req_drain", 32'(flush_req_o), 32'd1);
        flush_ack_i = 1'b1;
        tick();
        flush_ack_i = 1'b0;
        chk("flush_req_commit", 32'(flush_req_o), 32'd0);
    endtask

    task automatic redirect(input int hold, input bit exc_during);
        int n = 0;
        tick();
        chk("redirect_latency", 32'(redirect_valid_o), 32'd1);
        while (!redirect_valid_o && n < 20) begin tick(); n++; end
        if (!redirect_valid_o) return;
        exc_valid_i = exc_during; exc_cause_i = 5'd1; exc_pc_i = 32'h7770;
        for (int i = 0; i < hold; i++) begin
            chk("evt_ready_redirect", 32'(evt_ready_o), 32'd0);
            tick();
        end
        redirect_ready_i = 1'b1;
        tick();
        redirect_ready_i = 1'b0;
        exc_valid_i = 1'b0;
        chk("evt_ready_after", 32'(evt_ready_o), 32'd1);
    endtask

    task automatic irq_event(input bit e, input bit s, input bit t, input logic [31:0] npc);
        bit pe, ps, pt;
        int code;
        next_pc_i = npc;
        irq_ext_i = e; irq_sw_i = s; irq_timer_i = t;
        tick();
        pe = e & m_mie_reg[11] & m_mie;
        ps = s & m_mie_reg[3] & m_mie;
        pt = t & m_mie_reg[7] & m_mie;
        chk("irq_pending", 32'(irq_pending_o), 32'(pe | ps | pt));
        if (!(pe | ps | pt)) begin
            csr_addr_i = 12'h344; #1;
            chk("csr_mip", csr_rdata_o, (32'(e) << 11) | (32'(t) << 7) | (32'(s) << 3));
            irq_ext_i = 0; irq_sw_i = 0; irq_timer_i = 0;
            tick(); tick();
            return;
        end
        code = pe ? 11 : (ps ? 3 : 7);
        m_trap(1, code, npc, 32'h0);
        tick();
        irq_ext_i = 0; irq_sw_i = 0; irq_timer_i = 0;
        chk("evt_ready_drain", 32'(evt_ready_o), 32'd0);
        drain(int'($urandom_range(0, 2)), 0);
        redirect(int'($urandom_range(0, 2)), 0);
        tick();
    endtask

    localparam int NADDR = 9;
    logic [11:0] addrs [NADDR] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340,
                                   12'h341, 12'h342, 12'h343, 12'h344};

    initial begin
        m_reset();
        tick(); tick();
        do_reset();
        // Reset state
        chk("rst_evt_ready", 32'(evt_ready_o), 32'd1);
        chk("rst_flush_req", 32'(flush_req_o), 32'd0);
        chk("rst_redirect_valid", 32'(redirect_valid_o), 32'd0);
        chk("rst_redirect_pc", redirect_pc_o, 32'd0);
        csr_read(12'h300); csr_read(12'h301); csr_read(12'h305);
        csr_addr_i = 12'h7C0; #1;
        chk("csr_illegal_7c0", 32'(csr_illegal_o), 32'd1);

        // Synchronous exception with delayed ack and held redirect
        csr_write(12'h305, 32'h100);
        issue_exc(5'd2, 32'h80, 32'hDEAD);
        drain(2, 0);
        redirect(3, 0);
        csr_read(12'h341); csr_read(12'h342); csr_read(12'h343); csr_read(12'h300);

        // External + timer together: external wins
        csr_write(12'h300, 32'h8);
        csr_write(12'h304, 32'h888);
        irq_event(1, 0, 1, 32'h444);
        csr_read(12'h342); csr_read(12'h341); csr_read(12'h300);
        if (VEC) begin
            csr_write(12'h305, 32'h101);
            csr_write(12'h300, 32'h8);
            irq_event(1, 0, 1, 32'h448);
            csr_write(12'h305, 32'h100);
        end

        // MRET beats a same-cycle exception
        csr_write(12'h341, 32'h200);
        csr_write(12'h300, 32'h80);
        issue_mret(1);
        drain(0, 0);
        redirect(1, 0);
        csr_read(12'h300); csr_read(12'h342);

        // CSR write in DRAIN dropped; exception during REDIRECT ignored
        csr_write(12'h340, 32'h1234_5678);
        issue_exc(5'd5, 32'h300, 32'h55);
        drain(2, 1);
        redirect(2, 1);
        chk("exc_ignored_idle", 32'(flush_req_o), 32'd0);
        csr_read(12'h340);

        // Reset while draining
        issue_exc(5'd7, 32'h600, 32'h66);
        chk("flush_before_rst", 32'(flush_req_o), 32'd1);
        do_reset();
        chk("rst_drain_flush", 32'(flush_req_o), 32'd0);
        chk("rst_drain_ready", 32'(evt_ready_o), 32'd1);
        csr_read(12'h341); csr_read(12'h300); csr_read(12'h342);
        tick(); tick();
        chk("rst_drain_no_redirect", 32'(redirect_valid_o), 32'd0);

        // Randomized mix against the model
        csr_write(12'h305, 32'h400);
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 5))
                0: csr_write(addrs[$urandom_range(0, NADDR - 1)], $urandom);
                1: csr_read(addrs[$urandom_range(0, NADDR - 1)]);
                2: begin
                    issue_exc(5'($urandom_range(0, 31)), $urandom, $urandom);
                    drain(int'($urandom_range(0, 3)), 0);
                    redirect(int'($urandom_range(0, 3)), 0);
                    csr_read(12'h341); csr_read(12'h342);
                end
                3: begin
                    if ($urandom_range(0, 1) == 1) begin
                        csr_write(12'h300, 32'h8);
                        csr_write(12'h304, 32'h888);
                    end
                    irq_event(1'($urandom), 1'($urandom), 1'($urandom), $urandom);
                    csr_read(12'h342);
                end
                4: begin
                    issue_mret(0);
                    drain(int'($urandom_range(0, 3)), 0);
                    redirect(int'($urandom_range(0, 3)), 0);
                    csr_read(12'h300);
                end
                default: begin
                    csr_addr_i = 12'h7C0 | 12'($urandom_range(0, 15)); #1;
                    chk("csr_illegal_rand", 32'(csr_illegal_o), 32'd1);
                end
            endcase
        end
        tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
